// File: rtl/keypad_entry.sv
// ---------------------------------------------------------------------------
// keypad_entry
//   4x4 matrix keypad scanner with debounce, plus a two-field numeric entry
//   front end (two 0..99 values and a commit pulse).
//
//   Ports
//     sys_clk    in   clock, all logic on the rising edge
//     sys_rst_n  in   synchronous active-low reset
//     key_col    in   [3:0] keypad columns, active-low, asynchronous
//     key_row    out  [3:0] row drive, one-hot low
//     key_valid  out  one-cycle pulse per accepted press
//     key_code   out  [3:0] legend of the last accepted key
//     freq_a     out  [7:0] field A, 0..99
//     freq_b     out  [7:0] field B, 0..99
//     field_sel  out  0 = editing field A, 1 = field B
//     wr_start   out  one-cycle commit pulse
// ---------------------------------------------------------------------------
module keypad_entry #(
    parameter int SCAN_CNT = 50_000,
    parameter int DEB_CNT  = 20
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] key_col,
    output logic [3:0] key_row,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [7:0] freq_a,
    output logic [7:0] freq_b,
    output logic       field_sel,
    output logic       wr_start
);

    localparam int SW = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
    localparam int DW = $clog2(DEB_CNT + 1);

    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HOLD} state_t;

    state_t          r_state;
    logic [3:0]      r_col_s1, r_col_s2;
    logic [SW-1:0]   r_slot;
    logic [3:0]      r_row;
    logic [3:0]      r_latch;
    logic [1:0]      r_col_idx;
    logic [DW-1:0]   r_deb_cnt;
    logic [DW-1:0]   r_rel_cnt;
    logic            r_key_valid;
    logic [3:0]      r_key_code;
    logic [7:0]      r_freq_a, r_freq_b;
    logic            r_sel;
    logic            r_wr;

    logic            w_slot_end;
    logic            w_one_low;
    logic [1:0]      w_col_idx;
    logic [1:0]      w_row_idx;
    logic [3:0]      w_row_rot;
    logic [7:0]      w_sel_field;
    logic [7:0]      w_digit_val;

    // Row r / column c -> key legend ('*' = E, '#' = F).
    function automatic logic [3:0] legend(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] v;
        case ({r, c})
            4'h0: v = 4'h1;  4'h1: v = 4'h2;  4'h2: v = 4'h3;  4'h3: v = 4'hA;
            4'h4: v = 4'h4;  4'h5: v = 4'h5;  4'h6: v = 4'h6;  4'h7: v = 4'hB;
            4'h8: v = 4'h7;  4'h9: v = 4'h8;  4'hA: v = 4'h9;  4'hB: v = 4'hC;
            4'hC: v = 4'hE;  4'hD: v = 4'h0;  4'hE: v = 4'hF;  default: v = 4'hD;
        endcase
        return v;
    endfunction

    assign w_slot_end = (r_slot == SW'(SCAN_CNT - 1));
    assign w_row_rot  = {r_row[2:0], r_row[3]};

    // Exactly one column low is the only pattern that can start a press;
    // multi-column chords fall into default and are ignored.
    always_comb begin
        w_one_low = 1'b1;
        w_col_idx = 2'd0;
        case (r_col_s2)
            4'b1110: w_col_idx = 2'd0;
            4'b1101: w_col_idx = 2'd1;
            4'b1011: w_col_idx = 2'd2;
            4'b0111: w_col_idx = 2'd3;
            default: w_one_low = 1'b0;
        endcase
    end

    always_comb begin
        case (r_row)
            4'b1101: w_row_idx = 2'd1;
            4'b1011: w_row_idx = 2'd2;
            4'b0111: w_row_idx = 2'd3;
            default: w_row_idx = 2'd0;
        endcase
    end

    // Scanner / debounce FSM. The row is frozen outside SCAN so the same
    // key stays visible while it is being debounced and released.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state     <= S_SCAN;
            r_col_s1    <= 4'hF;
            r_col_s2    <= 4'hF;
            r_slot      <= '0;
            r_row       <= 4'b1110;
            r_latch     <= 4'hF;
            r_col_idx   <= 2'd0;
            r_deb_cnt   <= '0;
            r_rel_cnt   <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'h0;
        end else begin
            r_col_s1    <= key_col;
            r_col_s2    <= r_col_s1;
            r_slot      <= w_slot_end ? '0 : r_slot + SW'(1);
            r_key_valid <= 1'b0;
            if (w_slot_end) begin
                case (r_state)
                    S_SCAN: begin
                        if (w_one_low) begin
                            r_latch   <= r_col_s2;
                            r_col_idx <= w_col_idx;
                            r_deb_cnt <= DW'(1);
                            r_state   <= S_DEBOUNCE;
                        end else begin
                            r_row <= w_row_rot;
                        end
                    end
                    S_DEBOUNCE: begin
                        if (r_col_s2 == r_latch) begin
                            // This match is the DEB_CNT-th sample: accept.
                            if (r_deb_cnt == DW'(DEB_CNT - 1)) begin
                                r_key_valid <= 1'b1;
                                r_key_code  <= legend(w_row_idx, r_col_idx);
                                r_deb_cnt   <= '0;
                                r_rel_cnt   <= '0;
                                r_state     <= S_HOLD;
                            end else begin
                                r_deb_cnt <= r_deb_cnt + DW'(1);
                            end
                        end else begin
                            r_state   <= S_SCAN;
                            r_row     <= w_row_rot;
                            r_deb_cnt <= '0;
                        end
                    end
                    S_HOLD: begin
                        if (r_col_s2 == 4'hF) begin
                            if (r_rel_cnt == DW'(DEB_CNT - 1)) begin
                                r_rel_cnt <= '0;
                                r_state   <= S_SCAN;
                                r_row     <= w_row_rot;
                            end else begin
                                r_rel_cnt <= r_rel_cnt + DW'(1);
                            end
                        end else begin
                            r_rel_cnt <= '0;
                        end
                    end
                    default: r_state <= S_SCAN;
                endcase
            end
        end
    end

    // (field mod 10)*10 + d never exceeds 99, so 8 bits hold every step.
    assign w_sel_field = r_sel ? r_freq_b : r_freq_a;
    assign w_digit_val = ((w_sel_field % 8'd10) * 8'd10) + {4'd0, r_key_code};

    // Entry actions, one cycle after key_valid.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_freq_a <= 8'd0;
            r_freq_b <= 8'd0;
            r_sel    <= 1'b0;
            r_wr     <= 1'b0;
        end else begin
            r_wr <= 1'b0;
            if (r_key_valid) begin
                if (r_key_code <= 4'd9) begin
                    if (r_sel) r_freq_b <= w_digit_val;
                    else       r_freq_a <= w_digit_val;
                end else begin
                    case (r_key_code)
                        4'hA: r_sel <= 1'b0;
                        4'hB: r_sel <= 1'b1;
                        4'hC: begin
                            if (r_sel) r_freq_b <= 8'd0;
                            else       r_freq_a <= 8'd0;
                        end
                        4'hD: r_wr <= 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign key_row   = r_row;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign freq_a    = r_freq_a;
    assign freq_b    = r_freq_b;
    assign field_sel = r_sel;
    assign wr_start  = r_wr;

endmodule
